// File: rtl/audio_dsm_out.sv
// rtl/audio_dsm_out.sv - fractional-rate sample fetch with stereo first-order delta-sigma output
// Pending/active double buffer between the upstream sample source and the two 1-bit modulators.
module audio_dsm_out #(
   parameter int DATA_WIDTH   = 16,
   parameter int FACTOR_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [FACTOR_WIDTH-1:0] factor_mul,
   input  logic [FACTOR_WIDTH-1:0] factor_div,
   output logic                    sample_req,
   input  logic                    sample_valid,
   input  logic [DATA_WIDTH-1:0]   sample_l,
   input  logic [DATA_WIDTH-1:0]   sample_r,
   output logic                    audio_l,
   output logic                    audio_r,
   output logic                    underrun,
   output logic                    overrun
);

   logic [FACTOR_WIDTH:0] racc;
   logic [FACTOR_WIDTH:0] racc_sum;
   logic [FACTOR_WIDTH:0] racc_next;
   logic                  tick;

   logic [DATA_WIDTH-1:0] pend_l, pend_r;
   logic                  pend_flag;
   logic [DATA_WIDTH-1:0] act_l, act_r;

   logic [DATA_WIDTH:0]   dacc_l, dacc_r;
   logic [DATA_WIDTH-1:0] u_l, u_r;

   // One guard bit keeps racc + mul exact while racc < div.
   always_comb begin
      racc_sum  = racc + {1'b0, factor_mul};
      racc_next = racc;
      tick      = 1'b0;
      if (factor_div == '0) begin
         racc_next = racc;
      end else if (factor_mul >= factor_div) begin
         racc_next = '0;
         tick      = 1'b1;
      end else if (racc_sum >= {1'b0, factor_div}) begin
         racc_next = racc_sum - {1'b0, factor_div};
         tick      = 1'b1;
      end else begin
         racc_next = racc_sum;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         racc       <= '0;
         sample_req <= 1'b0;
      end else begin
         racc       <= racc_next;
         sample_req <= tick;
      end
   end

   // A sample arriving on the tick itself bypasses pending and goes straight to active.
   always_ff @(posedge clk) begin
      if (reset) begin
         pend_l    <= '0;
         pend_r    <= '0;
         pend_flag <= 1'b0;
         act_l     <= '0;
         act_r     <= '0;
         underrun  <= 1'b0;
         overrun   <= 1'b0;
      end else if (tick && sample_valid) begin
         act_l     <= sample_l;
         act_r     <= sample_r;
         pend_flag <= 1'b0;
         if (pend_flag) overrun <= 1'b1;
      end else if (tick) begin
         if (pend_flag) begin
            act_l     <= pend_l;
            act_r     <= pend_r;
            pend_flag <= 1'b0;
         end else begin
            underrun <= 1'b1;
         end
      end else if (sample_valid) begin
         pend_l    <= sample_l;
         pend_r    <= sample_r;
         pend_flag <= 1'b1;
         if (pend_flag) overrun <= 1'b1;
      end
   end

   assign u_l = {~act_l[DATA_WIDTH-1], act_l[DATA_WIDTH-2:0]};
   assign u_r = {~act_r[DATA_WIDTH-1], act_r[DATA_WIDTH-2:0]};

   // The carry out of the offset-binary accumulator is the 1-bit output.
   always_ff @(posedge clk) begin
      if (reset) begin
         dacc_l  <= '0;
         dacc_r  <= '0;
         audio_l <= 1'b0;
         audio_r <= 1'b0;
      end else begin
         dacc_l  <= {1'b0, dacc_l[DATA_WIDTH-1:0]} + {1'b0, u_l};
         dacc_r  <= {1'b0, dacc_r[DATA_WIDTH-1:0]} + {1'b0, u_r};
         audio_l <= dacc_l[DATA_WIDTH];
         audio_r <= dacc_r[DATA_WIDTH];
      end
   end

endmodule

// File: tb/tb_audio_dsm_out.sv
// tb/tb_audio_dsm_out.sv - scoreboard bench for audio_dsm_out
// Tick times come from floor(k*mul/div) steps; pin duty from total carries of n additions.
module tb_audio_dsm_out;
   localparam int DW = 16;
   localparam int FW = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [FW-1:0] factor_mul = '0;
   logic [FW-1:0] factor_div = '0;
   logic          sample_valid = 1'b0;
   logic [DW-1:0] sample_l = '0;
   logic [DW-1:0] sample_r = '0;
   logic          sample_req, audio_l, audio_r, underrun, overrun;

   int compared = 0;
   int mismatched = 0;
   int cyc = 0;
   int base = 0;
   int plen = 0;
   int exp_q[$];
   int win_lo = 32'h7fffffff;
   int win_hi = -1;
   int ones_l = 0;
   int ones_r = 0;

   audio_dsm_out #(.DATA_WIDTH(DW), .FACTOR_WIDTH(FW)) dut (
      .clk(clk), .reset(reset), .factor_mul(factor_mul), .factor_div(factor_div),
      .sample_req(sample_req), .sample_valid(sample_valid),
      .sample_l(sample_l), .sample_r(sample_r),
      .audio_l(audio_l), .audio_r(audio_r),
      .underrun(underrun), .overrun(overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s at cycle %0d: got %0d, required %0d", name, cyc, act, exp);
      end
   endtask

   // Monitor: every observed sample_req must match the next predicted tick cycle.
   always @(posedge clk) begin
      #1;
      if (sample_req) begin
         if (exp_q.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_sample_req at cycle %0d: got pulse, required none", cyc);
         end else begin
            chk("sample_req_cycle", cyc, exp_q.pop_front());
         end
      end
      if (cyc >= win_lo && cyc <= win_hi) begin
         ones_l += int'(audio_l);
         ones_r += int'(audio_r);
      end
   end

   // Called at a negedge: one reset edge, then n free-running edges with the given factors.
   task automatic start_phase(input logic [FW-1:0] m, input logic [FW-1:0] d, input int n);
      longint lm, ld;
      reset = 1'b1;
      factor_mul = m;
      factor_div = d;
      sample_valid = 1'b0;
      @(negedge clk);
      chk("reset_sample_req", sample_req, 0);
      chk("reset_audio_l", audio_l, 0);
      chk("reset_audio_r", audio_r, 0);
      chk("reset_underrun", underrun, 0);
      chk("reset_overrun", overrun, 0);
      reset = 1'b0;
      base = cyc;
      plen = n;
      exp_q.delete();
      lm = longint'(m);
      ld = longint'(d);
      for (longint k = 0; k < n; k++) begin
         if (ld != 0) begin
            if (lm >= ld || ((k + 1) * lm) / ld != (k * lm) / ld)
               exp_q.push_back(base + 1 + int'(k));
         end
      end
   endtask

   task automatic finish_phase();
      while (cyc != base + plen) @(negedge clk);
      chk("tick_queue_drained", exp_q.size(), 0);
      sample_valid = 1'b0;
      reset = 1'b1;
   endtask

   task automatic dsm_check(input logic [DW-1:0] sl, input logic [DW-1:0] sr, input int n);
      longint el, er;
      start_phase(1, 1, n + 2);
      sample_valid = 1'b1;
      sample_l = sl;
      sample_r = sr;
      ones_l = 0;
      ones_r = 0;
      win_lo = base + 3;
      win_hi = base + n + 2;
      finish_phase();
      win_lo = 32'h7fffffff;
      el = (32768 + longint'(n) * (longint'($signed(sl)) + 32768)) / 65536;
      er = (32768 + longint'(n) * (longint'($signed(sr)) + 32768)) / 65536;
      chk("dsm_ones_l", ones_l, el);
      chk("dsm_ones_r", ones_r, er);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: got no completion, required finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int j;
      logic [FW-1:0] rm, rd;

      // 48 kHz-style rate with a primed sample and a reply 5 cycles after each request
      start_phase(3, 1000, 20000);
      sample_valid = 1'b1;
      sample_l = DW'($urandom);
      sample_r = DW'($urandom);
      cnt = 0;
      while (cyc != base + plen) begin
         @(negedge clk);
         sample_valid = 1'b0;
         if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
               sample_valid = 1'b1;
               sample_l = DW'($urandom);
               sample_r = DW'($urandom);
            end
         end
         if (sample_req) cnt = 5;
      end
      chk("steady_underrun", underrun, 0);
      chk("steady_overrun", overrun, 0);
      finish_phase();

      dsm_check(16'h0000, 16'h0000, 1024);
      dsm_check(16'h7fff, 16'h8000, 4096);
      for (int i = 0; i < 4; i++)
         dsm_check(DW'($urandom), DW'($urandom), int'($urandom_range(200, 1000)));

      // Underrun without any samples, then overrun with last-wins delivery
      start_phase(1, 200, 500);
      while (cyc != base + plen) begin
         j = cyc - base;
         sample_valid = 1'b0;
         if (j == 199) chk("underrun_before_tick", underrun, 0);
         if (j == 200) chk("underrun_after_tick", underrun, 1);
         if (j == 210) begin
            chk("overrun_before", overrun, 0);
            sample_valid = 1'b1; sample_l = 16'h8000; sample_r = 16'h7fff;
         end
         if (j == 211) begin
            chk("overrun_one_pending", overrun, 0);
            sample_valid = 1'b1; sample_l = 16'h7fff; sample_r = 16'h8000;
         end
         if (j == 212) chk("overrun_set", overrun, 1);
         if (j == 401) begin
            ones_l = 0; ones_r = 0; win_lo = base + 402; win_hi = base + 500;
         end
         if (j == 450) chk("underrun_sticky", underrun, 1);
         @(negedge clk);
      end
      win_lo = 32'h7fffffff;
      chk("overrun_last_wins_l", ones_l >= 98, 1);
      chk("overrun_last_wins_r", ones_r <= 1, 1);
      chk("overrun_sticky", overrun, 1);
      finish_phase();

      // Rate corner cases
      start_phase(5, 0, 100);
      finish_phase();
      start_phase(5, 5, 50);
      finish_phase();
      start_phase(7, 10, 100);
      finish_phase();

      // Reset mid-stream with a sample pending must discard it
      start_phase(1, 10, 15);
      while (cyc != base + plen) begin
         j = cyc - base;
         sample_valid = (j == 0 || j == 12);
         sample_l = DW'($urandom);
         sample_r = DW'($urandom);
         if (j == 14) chk("primed_no_underrun", underrun, 0);
         @(negedge clk);
      end
      finish_phase();
      start_phase(1, 10, 30);
      while (cyc != base + plen) begin
         j = cyc - base;
         if (j == 9) chk("post_reset_underrun_before", underrun, 0);
         if (j == 10) chk("post_reset_underrun_after", underrun, 1);
         @(negedge clk);
      end
      finish_phase();

      // Randomized rates
      for (int i = 0; i < 6; i++) begin
         rd = $urandom_range(1, 40);
         rm = $urandom_range(0, int'(rd) + 3);
         start_phase(rm, rd, int'($urandom_range(50, 300)));
         finish_phase();
      end

      @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
